time_scheduler: RTL and testbench

- Global emulation-time controller that drives the shared `time_next` bus read by every `clock` instance.
- Each cycle it picks the minimum `time_clock` among enabled clocks and presents it as `time_next`, so only the earliest clock(s) advance.
- A run/pause/step/stop-time FSM gates advancement. When halted it drives the reserved `TIME_HALT` value, which no clock ever matches.

---
 rtl/time_scheduler_pkg.sv | 20 ++
 rtl/time_min_tree.sv | 38 +++
 rtl/time_scheduler.sv | 125 ++++++++++++
 tb/tb_time_scheduler.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/time_scheduler_pkg.sv
// rtl/time_scheduler_pkg.sv - shared time width, halt sentinel and scheduler state encoding
package time_scheduler_pkg;

  localparam int TIME_W = 64;
  localparam logic [TIME_W-1:0] TIME_HALT = '1;
  localparam int SCHED_STATE_WIDTH = 2;

  typedef enum logic [SCHED_STATE_WIDTH-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2,
    DONE = 2'd3
  } sched_state_t;

  // TIME_HALT is reserved as "no event", so a stop time can never reach it.
  function automatic logic [TIME_W-1:0] clamp_stop_time(input logic [TIME_W-1:0] t);
    return (t == TIME_HALT) ? TIME_HALT - TIME_W'(1) : t;
  endfunction

endpackage

// File: rtl/time_min_tree.sv
// rtl/time_min_tree.sv - masked binary min-reduction over packed clock times
module time_min_tree
  import time_scheduler_pkg::*;
#(
  parameter int NUM_CLOCKS = 2
) (
  input  logic [NUM_CLOCKS*TIME_W-1:0] times,
  input  logic [NUM_CLOCKS-1:0]        mask,
  output logic [TIME_W-1:0]            tmin
);

  localparam int LEAVES = (NUM_CLOCKS <= 1) ? 1 : (1 << $clog2(NUM_CLOCKS));

  logic [TIME_W-1:0] leaf [LEAVES];

  // Masked and padding leaves hold TIME_HALT so they never win the reduction.
  for (genvar g = 0; g < LEAVES; g++) begin : g_leaf
    if (g < NUM_CLOCKS) begin : g_real
      assign leaf[g] = mask[g] ? times[g*TIME_W +: TIME_W] : TIME_HALT;
    end else begin : g_pad
      assign leaf[g] = TIME_HALT;
    end
  end

  always_comb begin
    logic [TIME_W-1:0] node [LEAVES];
    for (int i = 0; i < LEAVES; i++) begin
      node[i] = leaf[i];
    end
    for (int w = LEAVES; w > 1; w = w / 2) begin
      for (int j = 0; j < w / 2; j++) begin
        node[j] = (node[2*j+1] < node[2*j]) ? node[2*j+1] : node[2*j];
      end
    end
    tmin = node[0];
  end

endmodule

// File: rtl/time_scheduler.sv
// rtl/time_scheduler.sv - global emulation-time controller driving the shared time_next bus
module time_scheduler
  import time_scheduler_pkg::*;
#(
  parameter int NUM_CLOCKS  = 2,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CLOCKS*TIME_W-1:0] time_clocks,
  input  logic [NUM_CLOCKS-1:0]        mask_in,
  input  logic                         mask_load,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         step_req,
  input  logic [COUNT_WIDTH-1:0]       num_steps,
  input  logic [TIME_W-1:0]            stop_time,
  output logic [TIME_W-1:0]            time_next,
  output logic [TIME_W-1:0]            time_curr,
  output logic [COUNT_WIDTH-1:0]       event_count,
  output logic [SCHED_STATE_WIDTH-1:0] state_out,
  output logic                         done
);

  sched_state_t           state_q, state_d;
  logic [NUM_CLOCKS-1:0]  mask_q, mask_d;
  logic [TIME_W-1:0]      stop_time_q, stop_time_d;
  logic [COUNT_WIDTH-1:0] steps_left_q, steps_left_d;
  logic [TIME_W-1:0]      time_curr_q, time_curr_d;
  logic [COUNT_WIDTH-1:0] event_count_q, event_count_d;

  logic [TIME_W-1:0] tmin;
  logic              past_end;
  logic              adv;

  time_min_tree #(.NUM_CLOCKS(NUM_CLOCKS)) u_min_tree (
    .times (time_clocks),
    .mask  (mask_q),
    .tmin  (tmin)
  );

  assign past_end  = (tmin == TIME_HALT) || (tmin > stop_time_q);
  assign adv       = ((state_q == RUN) || (state_q == STEP)) && !past_end;
  assign time_next = adv ? tmin : TIME_HALT;
  assign time_curr   = time_curr_q;
  assign event_count = event_count_q;
  assign state_out   = state_q;
  assign done        = (state_q == DONE);

  always_comb begin
    state_d       = state_q;
    mask_d        = mask_q;
    stop_time_d   = stop_time_q;
    steps_left_d  = steps_left_q;
    time_curr_d   = time_curr_q;
    event_count_d = event_count_q;

    if (adv) begin
      time_curr_d = tmin;
      if (event_count_q != '1) begin
        event_count_d = event_count_q + COUNT_WIDTH'(1);
      end
    end

    unique case (state_q)
      IDLE: begin
        if (mask_load) mask_d = mask_in;
        if (stop) begin
          state_d = IDLE;
        end else if (start) begin
          stop_time_d = clamp_stop_time(stop_time);
          state_d     = RUN;
        end else if (step_req && (num_steps != '0)) begin
          steps_left_d = num_steps;
          state_d      = STEP;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (past_end) begin
          state_d = DONE;
        end
      end
      STEP: begin
        if (stop) begin
          state_d      = IDLE;
          steps_left_d = '0;
        end else if (past_end) begin
          state_d = DONE;
        end else begin
          steps_left_d = steps_left_q - COUNT_WIDTH'(1);
          if (steps_left_q == COUNT_WIDTH'(1)) state_d = IDLE;
        end
      end
      DONE: begin
        if (mask_load) mask_d = mask_in;
        if (start) begin
          stop_time_d = clamp_stop_time(stop_time);
          state_d     = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      mask_q        <= '1;
      stop_time_q   <= '0;
      steps_left_q  <= '0;
      time_curr_q   <= '0;
      event_count_q <= '0;
    end else begin
      state_q       <= state_d;
      mask_q        <= mask_d;
      stop_time_q   <= stop_time_d;
      steps_left_q  <= steps_left_d;
      time_curr_q   <= time_curr_d;
      event_count_q <= event_count_d;
    end
  end

endmodule

// File: tb/tb_time_scheduler.sv
// tb/tb_time_scheduler.sv - directed bench for time_scheduler with a per-cycle reference model
module tb_time_scheduler;

  localparam int TW = 64;
  localparam int N  = 2;
  localparam int CW = 32;
  localparam logic [TW-1:0] HALT = {TW{1'b1}};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [TW-1:0] t0 = '0, t1 = '0;
  logic [N*TW-1:0] time_clocks;
  logic [N-1:0]  mask_in = '0;
  logic          mask_load = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          step_req = 1'b0;
  logic [CW-1:0] num_steps = '0;
  logic [TW-1:0] stop_time = '0;
  logic [TW-1:0] time_next;
  logic [TW-1:0] time_curr;
  logic [CW-1:0] event_count;
  logic [1:0]    state_out;
  logic          done;

  assign time_clocks = {t1, t0};

  time_scheduler #(.NUM_CLOCKS(N), .COUNT_WIDTH(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .time_clocks (time_clocks),
    .mask_in     (mask_in),
    .mask_load   (mask_load),
    .start       (start),
    .stop        (stop),
    .step_req    (step_req),
    .num_steps   (num_steps),
    .stop_time   (stop_time),
    .time_next   (time_next),
    .time_curr   (time_curr),
    .event_count (event_count),
    .state_out   (state_out),
    .done        (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model: mode 0 idle, 1 running, 2 stepping, 3 finished.
  int            m_mode;
  logic [N-1:0]  m_mask;
  logic [TW-1:0] m_stop, m_curr;
  logic [CW-1:0] m_steps, m_count;

  function automatic logic [TW-1:0] m_tmin();
    logic [TW-1:0] v [N];
    logic [TW-1:0] m;
    v[0] = t0;
    v[1] = t1;
    m = HALT;
    for (int i = 0; i < N; i++) if (m_mask[i] && v[i] < m) m = v[i];
    return m;
  endfunction

  function automatic bit m_adv();
    logic [TW-1:0] tm;
    tm = m_tmin();
    return (m_mode == 1 || m_mode == 2) && tm != HALT && tm <= m_stop;
  endfunction

  task automatic cmp(input string name, input logic [TW-1:0] got, input logic [TW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0; m_mask = '1; m_stop = '0; m_steps = '0; m_curr = '0; m_count = '0;
    end else begin
      logic [TW-1:0] tm;
      bit a;
      tm = m_tmin();
      a  = m_adv();
      if (a) begin
        m_curr = tm;
        if (m_count != {CW{1'b1}}) m_count = m_count + 1;
      end
      case (m_mode)
        0: begin
          if (mask_load) m_mask = mask_in;
          if (!stop) begin
            if (start) begin
              m_stop = (stop_time == HALT) ? HALT - 1 : stop_time;
              m_mode = 1;
            end else if (step_req && num_steps != 0) begin
              m_steps = num_steps;
              m_mode  = 2;
            end
          end
        end
        1: begin
          if (stop) m_mode = 0;
          else if (!a) m_mode = 3;
        end
        2: begin
          if (stop) begin
            m_mode = 0; m_steps = '0;
          end else if (!a) begin
            m_mode = 3;
          end else begin
            if (m_steps == 1) m_mode = 0;
            m_steps = m_steps - 1;
          end
        end
        default: begin
          if (mask_load) m_mask = mask_in;
          if (start) begin
            m_stop = (stop_time == HALT) ? HALT - 1 : stop_time;
            m_mode = 1;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("model_time_next", time_next, m_adv() ? m_tmin() : HALT);
      cmp("model_time_curr", time_curr, m_curr);
      cmp("model_event_count", TW'(event_count), TW'(m_count));
      cmp("model_state", TW'(state_out), TW'(m_mode));
      cmp("model_done", TW'(done), TW'(m_mode == 3));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [CW-1:0] e0;

  initial begin
    tick();
    tick();
    rst = 1'b0;
    chk_en = 1'b1;
    #1;
    cmp("reset_state", TW'(state_out), 0);
    cmp("reset_event_count", TW'(event_count), 0);
    cmp("reset_time_next", time_next, HALT);

    // First run from zero.
    start = 1'b1; stop_time = 100;
    tick(); start = 1'b0; #1;
    cmp("run_state", TW'(state_out), 1);
    cmp("first_time_next", time_next, 0);
    tick(); #1;
    cmp("first_event_count", TW'(event_count), 1);

    t0 = 5; t1 = 3; #1;
    cmp("min_5_3", time_next, 3);
    tick(); #1;
    cmp("time_curr_3", time_curr, 3);
    t1 = 8; #1;
    cmp("min_5_8", time_next, 5);

    // Past stop time, then restart with a later stop time.
    t0 = 120; t1 = 130; #1;
    cmp("past_stop_halt", time_next, HALT);
    tick(); #1;
    cmp("done_state", TW'(state_out), 3);
    cmp("done_flag", TW'(done), 1);
    start = 1'b1; stop_time = 200;
    tick(); start = 1'b0; #1;
    cmp("restart_state", TW'(state_out), 1);
    cmp("restart_time_next", time_next, 120);

    // Three single steps.
    stop = 1'b1;
    tick(); stop = 1'b0;
    t0 = 10; t1 = 20;
    e0 = m_count;
    step_req = 1'b1; num_steps = 3;
    tick(); step_req = 1'b0;
    repeat (3) tick();
    #1;
    cmp("step3_state", TW'(state_out), 0);
    cmp("step3_events", TW'(event_count), TW'(e0 + 3));
    step_req = 1'b1; num_steps = 0;
    tick(); step_req = 1'b0; #1;
    cmp("step0_state", TW'(state_out), 0);
    tick(); #1;
    cmp("step0_events", TW'(event_count), TW'(e0 + 3));

    // Mask load in IDLE honoured, during RUN ignored.
    mask_in = 2'b01; mask_load = 1'b1;
    tick(); mask_load = 1'b0;
    t0 = 10; t1 = 2;
    start = 1'b1; stop_time = 100;
    tick(); start = 1'b0; #1;
    cmp("masked_time_next", time_next, 10);
    mask_in = 2'b11; mask_load = 1'b1;
    tick(); mask_load = 1'b0;
    tick(); #1;
    cmp("mask_run_ignored", time_next, 10);

    // Start and stop together, then reset mid-step.
    stop = 1'b1;
    tick(); stop = 1'b0;
    start = 1'b1; stop = 1'b1;
    tick(); start = 1'b0; stop = 1'b0; #1;
    cmp("start_stop_idle", TW'(state_out), 0);
    step_req = 1'b1; num_steps = 5;
    tick(); step_req = 1'b0; #1;
    cmp("step5_state", TW'(state_out), 2);
    rst = 1'b1;
    tick(); rst = 1'b0; #1;
    cmp("rst_state", TW'(state_out), 0);
    cmp("rst_events", TW'(event_count), 0);
    cmp("rst_time_next", time_next, HALT);

    // Stop time equal to HALT is clamped to HALT-1.
    t0 = HALT - 1; t1 = HALT;
    start = 1'b1; stop_time = HALT;
    tick(); start = 1'b0; #1;
    cmp("clamp_time_next", time_next, HALT - 1);
    tick(); #1;
    cmp("clamp_time_curr", time_curr, HALT - 1);
    t0 = HALT;
    tick(); #1;
    cmp("all_halt_done", TW'(state_out), 3);

    // Empty mask loaded in DONE: run finds nothing and returns to DONE.
    mask_in = 2'b00; mask_load = 1'b1;
    tick(); mask_load = 1'b0;
    t0 = 1;
    start = 1'b1; stop_time = 50;
    tick(); start = 1'b0; #1;
    cmp("empty_mask_next", time_next, HALT);
    tick(); #1;
    cmp("empty_mask_done", TW'(state_out), 3);

    repeat (3) tick();
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
